fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port pc_o, output, 8: fetch byte address, wired to program memory address_i.
REQ-005 SHALL have port instr_mem_i, input, 32: combinational instruction word returned by program memory for pc_o, little-endian bytes.
REQ-006 SHALL have port redirect_i, input, 1: branch/jump redirect request.
REQ-007 SHALL have port redirect_pc_i, input, 8: redirect target address.
REQ-008 SHALL have port halt_i, input, 1: stop-fetch request.
REQ-009 SHALL have port instr_o, output, 32: fetched instruction to decode.
REQ-010 SHALL have port instr_pc_o, output, 8: address instr_o was fetched from.
REQ-011 SHALL have port valid_o, output, 1: instr_o/instr_pc_o hold a live instruction.
REQ-012 SHALL have port ready_i, input, 1: decode accepts the instruction this cycle.

Function
REQ-013 pc_o SHALL equal the internal PC register combinationally; no other logic SHALL drive it.
REQ-014 FSM SHALL have states FETCH and HALTED.
REQ-015 In FETCH, the output slot is free when valid_o=0 or (valid_o=1 and ready_i=1).
REQ-016 In FETCH with the slot free:
  - instr_o SHALL capture instr_mem_i.
  - instr_pc_o SHALL capture PC.
  - valid_o SHALL be set to 1.
  - PC SHALL advance by 4.
  - Fetch-to-valid latency is 1 cycle.
REQ-017 In FETCH with the slot not free (valid_o=1, ready_i=0), instr_o, instr_pc_o, valid_o and PC SHALL hold.
REQ-018 PC arithmetic SHALL be 8-bit modulo: 8'hFC + 4 = 8'h00, with no flag or stall.
REQ-019 A transfer SHALL occur exactly when valid_o=1 and ready_i=1; each instruction SHALL transfer exactly once.
REQ-020 redirect_i=1 SHALL have highest priority, in any state:
  - PC <= {redirect_pc_i[7:2], 2'b00}.
  - valid_o <= 0, discarding any held instruction even if ready_i=1.
  - state <= FETCH.
  - No capture that cycle.
REQ-021 After a redirect, the first instruction from the new target SHALL appear with valid_o=1 two cycles after the redirect edge.
REQ-022 halt_i=1 with redirect_i=0 in FETCH SHALL:
  - move state to HALTED;
  - inhibit capture and PC increment that cycle.
REQ-023 In HALTED:
  - PC SHALL hold;
  - no new capture SHALL occur;
  - a held valid instruction SHALL remain until transferred, after which valid_o=0.
REQ-024 HALTED SHALL be left only by redirect_i or rst_i; deasserting halt_i alone SHALL NOT resume fetch.
REQ-025 With simultaneous redirect_i and halt_i, redirect SHALL win and halt_i SHALL be ignored.
REQ-026 instr_o and instr_pc_o SHALL be don't-care when valid_o=0, but SHALL be driven from registers only.

Reset
REQ-027 On rst_i=1 at a clock edge:
  - PC <= RESET_PC;
  - state <= FETCH;
  - valid_o <= 0;
  - instr_o <= 32'h0;
  - instr_pc_o <= 8'h0.
REQ-028 rst_i SHALL override redirect_i and halt_i, and any held instruction SHALL be discarded.
REQ-029 In the first cycle after reset release, pc_o=RESET_PC; valid_o=1 SHALL follow one cycle later.

Structure
REQ-030 A shared package feather_pkg SHALL hold:
  - the FSM state typedef fetch_state_t {FETCH, HALTED};
  - PC_WIDTH=8, INSTR_WIDTH=32 and PC_STEP=4.
REQ-031 One sub-module is natural: fetch_out_reg, a valid/ready output register holding instr and pc with flush input; the PC/FSM logic SHALL remain in fetch_unit.
REQ-032 The bench SHALL instantiate fetch_unit with program_memory, connecting pc_o to address_i and instr_mem_i to instruction_i.

Verification
REQ-033 Streaming: reset, then ready_i=1 held with program bytes 00..0B -> valid_o rises cycle 2; instr_o = 32'h03020100, 32'h07060504, 32'h0B0A0908 on consecutive cycles; instr_pc_o = 0x00, 0x04, 0x08.
REQ-034 Backpressure: ready_i=0 for 3 cycles while valid_o=1, instr_pc_o=0x04 -> instr_o, instr_pc_o and pc_o=0x08 stable; on ready_i=1, the next instruction (pc 0x08) appears the following cycle with no duplicate and no loss.
REQ-035 Redirect: redirect_i=1, redirect_pc_i=8'h23 while valid_o=1 and ready_i=1 -> valid_o=0 next cycle, pc_o=0x20; valid_o=1 with instr_pc_o=0x20 one cycle later.
REQ-036 Wrap: RESET_PC=8'hF8 -> instr_pc_o sequence 0xF8, 0xFC, 0x00, 0x04.
REQ-037 Halt: halt_i=1 with valid_o=1, ready_i=0 for 2 cycles, then ready_i=1 -> the held instruction transfers once, then valid_o=0 and pc_o constant; after halt_i deassert, still no fetch; redirect_pc_i=8'h10 resumes at 0x10.
REQ-038 Reset mid-stream: rst_i=1 while valid_o=1 and redirect_i=1 -> next cycle valid_o=0 and pc_o=RESET_PC, with the redirect ignored.

Source files
------------

// File: rtl/feather_pkg.sv
// Shared types and constants for the feather fetch front end.
package feather_pkg;

  localparam int unsigned PC_WIDTH    = 8;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] PC_STEP = 8'd4;

  typedef enum logic {
    FETCH,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register holding a fetched instruction and its address.
module fetch_out_reg
  import feather_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   load_i,
  input  logic                   ready_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [PC_WIDTH-1:0]    pc_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic                   valid_o
);

  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic                   valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      // Flush wins over a load or a pending transfer.
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (load_i) begin
        valid_q <= 1'b1;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
      if (load_i && !flush_i) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/program_memory.sv
// Combinational program ROM whose byte at address a holds the value a (little-endian words).
module program_memory
  import feather_pkg::*;
(
  input  logic [PC_WIDTH-1:0]    address_i,
  output logic [INSTR_WIDTH-1:0] instruction_i
);

  logic [PC_WIDTH-1:0] byte1, byte2, byte3;

  always_comb begin
    byte1         = address_i + 8'd1;
    byte2         = address_i + 8'd2;
    byte3         = address_i + 8'd3;
    instruction_i = {byte3, byte2, byte1, address_i};
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, FETCH/HALTED control and a one-entry output slot.
module fetch_unit
  import feather_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 8'h00
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [PC_WIDTH-1:0]    pc_o,
  input  logic [INSTR_WIDTH-1:0] instr_mem_i,
  input  logic                   redirect_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  input  logic                   halt_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    instr_pc_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  fetch_state_t        state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                slot_free;
  logic                load;
  logic                unused_redirect_lsb;

  // Redirect targets are forced to word alignment, so the low bits are dropped.
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign slot_free = !valid_o || ready_i;
  assign load      = (state_q == FETCH) && !redirect_i && !halt_i && slot_free;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH;
    end else if (redirect_i) begin
      pc_q    <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
      state_q <= FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (halt_i) begin
            state_q <= HALTED;
          end else if (slot_free) begin
            pc_q <= pc_q + PC_STEP;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign pc_o = pc_q;

  fetch_out_reg u_out (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .load_i  (load),
    .ready_i (ready_i),
    .instr_i (instr_mem_i),
    .pc_i    (pc_q),
    .instr_o (instr_o),
    .pc_o    (instr_pc_o),
    .valid_o (valid_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit driven by an identity-pattern program memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, redirect, halt, ready;
  logic [7:0]  redirect_pc;

  logic [7:0]  pc0, ipc0, pc1, ipc1;
  logic [31:0] mem0, mem1, instr0, instr1;
  logic        valid0, valid1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(8'h00)) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_o          (pc0),
    .instr_mem_i   (mem0),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .halt_i        (halt),
    .instr_o       (instr0),
    .instr_pc_o    (ipc0),
    .valid_o       (valid0),
    .ready_i       (ready)
  );

  program_memory u_mem0 (
    .address_i     (pc0),
    .instruction_i (mem0)
  );

  fetch_unit #(.RESET_PC(8'hF8)) u_dut_wrap (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_o          (pc1),
    .instr_mem_i   (mem1),
    .redirect_i    (1'b0),
    .redirect_pc_i (8'h00),
    .halt_i        (1'b0),
    .instr_o       (instr1),
    .instr_pc_o    (ipc1),
    .valid_o       (valid1),
    .ready_i       (1'b1)
  );

  program_memory u_mem1 (
    .address_i     (pc1),
    .instruction_i (mem1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; halt = 1'b0; ready = 1'b0; redirect_pc = 8'h00;
    tick(); tick();
    check("rst_valid", {31'b0, valid0}, 32'h0);
    check("rst_pc", {24'b0, pc0}, 32'h0);
    check("rst_instr", instr0, 32'h0);
    check("rst_ipc", {24'b0, ipc0}, 32'h0);

    // Streaming
    rst = 1'b0; ready = 1'b1;
    check("rel_pc", {24'b0, pc0}, 32'h0);
    tick();
    check("s0_valid", {31'b0, valid0}, 32'h1);
    check("s0_instr", instr0, 32'h03020100);
    check("s0_ipc", {24'b0, ipc0}, 32'h00);
    tick();
    check("s1_instr", instr0, 32'h07060504);
    check("s1_ipc", {24'b0, ipc0}, 32'h04);

    // Backpressure on the 0x04 instruction
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", {31'b0, valid0}, 32'h1);
      check("bp_instr", instr0, 32'h07060504);
      check("bp_ipc", {24'b0, ipc0}, 32'h04);
      check("bp_pc", {24'b0, pc0}, 32'h08);
    end
    ready = 1'b1;
    tick();
    check("s2_instr", instr0, 32'h0B0A0908);
    check("s2_ipc", {24'b0, ipc0}, 32'h08);
    tick();
    check("s3_ipc", {24'b0, ipc0}, 32'h0C);

    // Redirect with a live, accepted instruction
    redirect = 1'b1; redirect_pc = 8'h23;
    tick();
    check("rd_valid", {31'b0, valid0}, 32'h0);
    check("rd_pc", {24'b0, pc0}, 32'h20);
    redirect = 1'b0;
    tick();
    check("rd1_valid", {31'b0, valid0}, 32'h1);
    check("rd1_ipc", {24'b0, ipc0}, 32'h20);
    check("rd1_instr", instr0, 32'h23222120);

    // Halt while holding the 0x20 instruction
    ready = 1'b0; halt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("h_valid", {31'b0, valid0}, 32'h1);
      check("h_ipc", {24'b0, ipc0}, 32'h20);
      check("h_pc", {24'b0, pc0}, 32'h24);
    end
    ready = 1'b1;
    tick();
    check("h_xfer_valid", {31'b0, valid0}, 32'h0);
    check("h_xfer_pc", {24'b0, pc0}, 32'h24);
    tick();
    check("h_idle_valid", {31'b0, valid0}, 32'h0);
    halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("h_stay_valid", {31'b0, valid0}, 32'h0);
      check("h_stay_pc", {24'b0, pc0}, 32'h24);
    end
    redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    check("h_res_pc", {24'b0, pc0}, 32'h10);
    redirect = 1'b0;
    tick();
    check("h_res_valid", {31'b0, valid0}, 32'h1);
    check("h_res_ipc", {24'b0, ipc0}, 32'h10);
    check("h_res_instr", instr0, 32'h13121110);

    // Redirect and halt together: redirect wins
    redirect = 1'b1; halt = 1'b1; redirect_pc = 8'h41;
    tick();
    check("rh_pc", {24'b0, pc0}, 32'h40);
    redirect = 1'b0; halt = 1'b0;
    tick();
    check("rh_valid", {31'b0, valid0}, 32'h1);
    check("rh_ipc", {24'b0, ipc0}, 32'h40);

    // Reset overrides redirect mid-stream
    rst = 1'b1; redirect = 1'b1; redirect_pc = 8'h80;
    tick();
    check("mr_valid", {31'b0, valid0}, 32'h0);
    check("mr_pc", {24'b0, pc0}, 32'h00);
    check("mr_wrap_pc", {24'b0, pc1}, 32'hF8);
    rst = 1'b0; redirect = 1'b0;
    tick();
    check("mr_ipc", {24'b0, ipc0}, 32'h00);
    check("mr_valid1", {31'b0, valid0}, 32'h1);

    // Wrap on the RESET_PC=F8 instance
    check("w0_ipc", {24'b0, ipc1}, 32'hF8);
    check("w0_instr", instr1, 32'hFBFAF9F8);
    tick();
    check("w1_ipc", {24'b0, ipc1}, 32'hFC);
    check("w1_instr", instr1, 32'hFFFEFDFC);
    check("w1_pc", {24'b0, pc1}, 32'h00);
    tick();
    check("w2_ipc", {24'b0, ipc1}, 32'h00);
    check("w2_instr", instr1, 32'h03020100);
    tick();
    check("w3_ipc", {24'b0, ipc1}, 32'h04);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
